steer_en_ctrl: RTL and testbench

//  Parametrised steering-enable controller for the Segway platform.
//  - Takes left/right load-cell readings and decides when the rider is on, balanced and

---
 rtl/steer_en_ctrl.sv | 139 +++++++++++++
 tb/tb_steer_en_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/steer_en_ctrl.sv
// Steering-enable controller for the load-cell front end.
// Decides from left/right load readings when the rider is on and balanced,
// and enables steering after a settle period. Weight thresholds carry
// hysteresis, and the steering disable is debounced over DIS_CYC cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no rider present; rider_off asserted
// WAIT  | rider present, settle timer running while balanced
// STEER | steering enabled; debounced imbalance returns to WAIT
module steer_en_ctrl #(
  parameter int unsigned LD_W      = 12,
  parameter int unsigned MIN_WT    = 32'h200,
  parameter int unsigned WT_HYST   = 32'h040,
  parameter int unsigned EN_SHIFT  = 3,
  parameter int unsigned DIS_SHIFT = 4,
  parameter int unsigned DIS_CYC   = 1,
  parameter int unsigned TMR_W     = 26,
  parameter int unsigned FAST_SIM  = 0,
  parameter int unsigned FAST_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_load,
  input  logic [LD_W-1:0] rght_load,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      steer_st
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] STEER = 2'b10;

  localparam int unsigned HI_TH_I = MIN_WT + WT_HYST;
  localparam int unsigned LO_TH_I = MIN_WT - WT_HYST;
  localparam logic [LD_W:0] HI_TH = HI_TH_I[LD_W:0];
  localparam logic [LD_W:0] LO_TH = LO_TH_I[LD_W:0];
  localparam int unsigned DIS_LAST_I = DIS_CYC - 1;
  localparam logic [7:0] DIS_LAST = DIS_LAST_I[7:0];

  logic [1:0]      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]      dis_q, dis_d;
  logic            en_steer_q, rider_off_q;

  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;
  logic [LD_W:0]   en_lim;
  logic [LD_W:0]   dis_lim;
  logic            sum_gt_min, sum_lt_min;
  logic            diff_gt_en, diff_gt_dis;
  logic            tmr_full;

  // Load arithmetic; all comparisons are unsigned and done at LD_W+1 bits.
  always_comb begin
    sum         = {1'b0, lft_load} + {1'b0, rght_load};
    diff        = (lft_load >= rght_load) ? (lft_load - rght_load) : (rght_load - lft_load);
    en_lim      = sum >> EN_SHIFT;
    dis_lim     = sum - (sum >> DIS_SHIFT);
    sum_gt_min  = sum > HI_TH;
    sum_lt_min  = sum < LO_TH;
    diff_gt_en  = {1'b0, diff} > en_lim;
    diff_gt_dis = {1'b0, diff} > dis_lim;
  end

  // In fast-sim mode only the low timer bits define the settle period.
  assign tmr_full = (FAST_SIM != 0) ? (&tmr_q[FAST_W-1:0]) : (&tmr_q);

  // Next-state, settle timer and disable debounce counter.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dis_d   = dis_q;
    case (state_q)
      IDLE: begin
        dis_d = '0;
        if (sum_gt_min) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      WAIT: begin
        dis_d = '0;
        if (sum_lt_min) begin
          state_d = IDLE;
        end else if (diff_gt_en) begin
          tmr_d = '0;
        end else if (tmr_full) begin
          state_d = STEER;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          state_d = IDLE;
          dis_d   = '0;
        end else if (diff_gt_dis) begin
          if (dis_q >= DIS_LAST) begin
            state_d = WAIT;
            tmr_d   = '0;
            dis_d   = '0;
          end else begin
            dis_d = dis_q + 8'd1;
          end
        end else begin
          dis_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        dis_d   = '0;
      end
    endcase
  end

  // State registers; outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      dis_q       <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      dis_q       <= dis_d;
      en_steer_q  <= (state_d == STEER);
      rider_off_q <= (state_d == IDLE);
    end
  end

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;
  assign steer_st  = state_q;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Testbench for steer_en_ctrl: directed phases plus a random run, all
// checked through a scoreboard fed by a behavioural reference model.
module tb_steer_en_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] lft_load;
  logic [11:0] rght_load;
  logic        en_steer;
  logic        rider_off;
  logic [1:0]  steer_st;

  int n_vec;
  int n_err;

  logic [3:0] sb_q[$];

  int m_st;
  int m_tmr;
  int m_dis;

  steer_en_ctrl #(
    .LD_W(12), .MIN_WT(32'h200), .WT_HYST(32'h040), .EN_SHIFT(3), .DIS_SHIFT(4),
    .DIS_CYC(3), .TMR_W(26), .FAST_SIM(1), .FAST_W(4)
  ) dut (
    .clk(clk), .rst(rst), .lft_load(lft_load), .rght_load(rght_load),
    .en_steer(en_steer), .rider_off(rider_off), .steer_st(steer_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: advances one clock edge for the given inputs.
  task automatic model_step(input logic r, input int l, input int rt);
    int sum, diff;
    bit gt_min, lt_min, gt_en, gt_dis;
    sum    = l + rt;
    diff   = (l > rt) ? l - rt : rt - l;
    gt_min = sum > 'h240;
    lt_min = sum < 'h1C0;
    gt_en  = diff > (sum / 8);
    gt_dis = diff > (sum - sum / 16);
    if (r) begin
      m_st = 0; m_tmr = 0; m_dis = 0;
    end else begin
      case (m_st)
        0: if (gt_min) begin m_st = 1; m_tmr = 0; end
        1: begin
          if (lt_min) m_st = 0;
          else if (gt_en) m_tmr = 0;
          else if ((m_tmr % 16) == 15) m_st = 2;
          else m_tmr++;
        end
        default: begin
          if (lt_min) begin m_st = 0; m_dis = 0; end
          else if (gt_dis) begin
            if (m_dis == 2) begin m_st = 1; m_tmr = 0; m_dis = 0; end
            else m_dis++;
          end else m_dis = 0;
        end
      endcase
    end
  endtask

  // One clock: drive inputs, push expected {st,en,off}, sample after the edge.
  task automatic cyc(input string tag, input logic r, input logic [11:0] l, input logic [11:0] rt);
    logic [3:0] exp;
    rst = r; lft_load = l; rght_load = rt;
    model_step(r, int'(l), int'(rt));
    sb_q.push_back({2'(m_st), (m_st == 2), (m_st == 0)});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    chk(tag, {28'd0, steer_st, en_steer, rider_off}, {28'd0, exp});
  endtask

  initial begin
    int first_en;
    logic [11:0] l, rt;
    n_vec = 0; n_err = 0;
    m_st = 0; m_tmr = 0; m_dis = 0;
    rst = 1'b1; lft_load = '0; rght_load = '0;

    // reset and idle with no load
    repeat (2) cyc("rst", 1'b1, 12'h000, 12'h000);
    repeat (4) cyc("idle", 1'b0, 12'h000, 12'h000);
    chk("idle_st", {30'd0, steer_st}, 32'd0);

    // unbalanced rider: WAIT with timer held
    repeat (6) cyc("wait_unbal", 1'b0, 12'h400, 12'h000);
    chk("wait_st", {30'd0, steer_st}, 32'd1);

    // balanced: steering enabled on the 16th edge
    first_en = 0;
    for (int i = 1; i <= 18; i++) begin
      cyc("settle", 1'b0, 12'h400, 12'h400);
      if (en_steer && first_en == 0) first_en = i;
    end
    chk("lat16", first_en, 32'd16);

    // disable debounce
    repeat (4) cyc("steer_bal", 1'b0, 12'h400, 12'h200);
    repeat (2) cyc("dis_short", 1'b0, 12'h400, 12'h008);
    cyc("dis_rel", 1'b0, 12'h400, 12'h200);
    chk("dis_rel_en", {31'd0, en_steer}, 32'd1);
    repeat (2) cyc("dis_hold", 1'b0, 12'h400, 12'h008);
    chk("dis2_en", {31'd0, en_steer}, 32'd1);
    cyc("dis_3rd", 1'b0, 12'h400, 12'h008);
    chk("dis3_st", {30'd0, steer_st}, 32'd1);
    chk("dis3_en", {31'd0, en_steer}, 32'd0);

    // hysteresis band edges
    cyc("to_idle", 1'b0, 12'h000, 12'h000);
    repeat (2) cyc("hy_240", 1'b0, 12'h120, 12'h120);
    chk("hy_240_st", {30'd0, steer_st}, 32'd0);
    cyc("hy_241", 1'b0, 12'h120, 12'h121);
    chk("hy_241_st", {30'd0, steer_st}, 32'd1);
    repeat (2) cyc("hy_1c0", 1'b0, 12'h0E0, 12'h0E0);
    chk("hy_1c0_st", {30'd0, steer_st}, 32'd1);
    cyc("hy_1bf", 1'b0, 12'h0E0, 12'h0DF);
    chk("hy_1bf_off", {31'd0, rider_off}, 32'd1);

    // rider_off wins over disable in STEER
    repeat (17) cyc("to_steer", 1'b0, 12'h400, 12'h400);
    chk("steer_a", {31'd0, en_steer}, 32'd1);
    cyc("off_wins", 1'b0, 12'h120, 12'h040);
    chk("off_wins_st", {30'd0, steer_st}, 32'd0);

    // reset from STEER, then re-enter WAIT
    repeat (17) cyc("to_steer2", 1'b0, 12'h400, 12'h400);
    chk("steer_b", {31'd0, en_steer}, 32'd1);
    cyc("rst_steer", 1'b1, 12'h400, 12'h400);
    cyc("post_rst", 1'b0, 12'h400, 12'h400);
    chk("post_rst_st", {30'd0, steer_st}, 32'd1);

    // random run around the thresholds
    for (int i = 0; i < 400; i++) begin
      l = 12'($urandom_range(0, 'h500));
      if ($urandom_range(0, 3) == 0) rt = 12'($urandom_range(0, 'h500));
      else rt = l + 12'($urandom_range(0, 8));
      cyc("rand", ($urandom_range(0, 60) == 0), l, rt);
      chk("excl", {31'd0, en_steer & rider_off}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
